// File: rtl/max_min_pkg.sv
// Shared types and constants for the max_min comparator and its stream controller.
// Holds the sample width, group size, controller state encoding and compare helpers.
package max_min_pkg;

  localparam int DATA_W  = 4;
  localparam int GROUP_N = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MERGE   = 2'd1,
    DONE    = 2'd2
  } state_e;

  function automatic logic [DATA_W-1:0] max_of(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    return (x >= y) ? x : y;
  endfunction

  function automatic logic [DATA_W-1:0] min_of(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    return (x >= y) ? y : x;
  endfunction

endpackage

// File: rtl/max_min.sv
// Combinational top-two of four unsigned values (multiset: duplicates count).
// max1 >= max2 always holds on the outputs.
module max_min
  import max_min_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] max1,
  output logic [DATA_W-1:0] max2
);

  logic [DATA_W-1:0] hi_ab_s;
  logic [DATA_W-1:0] lo_ab_s;
  logic [DATA_W-1:0] hi_cd_s;
  logic [DATA_W-1:0] lo_cd_s;

  // Pairwise sort, then the runner-up is the best of the winning pair's loser and the losing pair's winner.
  always_comb begin
    hi_ab_s = max_of(a, b);
    lo_ab_s = min_of(a, b);
    hi_cd_s = max_of(c, d);
    lo_cd_s = min_of(c, d);
    max1    = max_of(hi_ab_s, hi_cd_s);
    if (hi_ab_s >= hi_cd_s) begin
      max2 = max_of(lo_ab_s, hi_cd_s);
    end else begin
      max2 = max_of(hi_ab_s, lo_cd_s);
    end
  end

endmodule

// File: rtl/max_min_stream_ctrl.sv
// Packs a sample stream into groups of four, folds each group into a running top-two,
// and presents the frame's two largest samples plus a saturating count at frame end.
module max_min_stream_ctrl #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_max1,
  output logic [DATA_W-1:0] out_max2,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_valid,
  input  logic              out_ready
);

  import max_min_pkg::*;

  localparam int IDX_W = $clog2(GROUP_N);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [DATA_W-1:0] slot_r [GROUP_N];
  logic [IDX_W-1:0]  slot_idx_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] run1_r;
  logic [DATA_W-1:0] run2_r;
  logic [DATA_W-1:0] g1_s;
  logic [DATA_W-1:0] g2_s;
  logic [DATA_W-1:0] m1_s;
  logic [DATA_W-1:0] m2_s;
  logic              last_r;
  logic              accept_s;
  logic              group_end_s;

  assign in_ready    = (state_r == COLLECT) && !sys_rst;
  assign accept_s    = in_valid && in_ready;
  assign group_end_s = (slot_idx_r == IDX_W'(GROUP_N - 1)) || in_last;

  max_min u_group (
    .a   (slot_r[0]),
    .b   (slot_r[1]),
    .c   (slot_r[2]),
    .d   (slot_r[3]),
    .max1(g1_s),
    .max2(g2_s)
  );

  max_min u_merge (
    .a   (run1_r),
    .b   (run2_r),
    .c   (g1_s),
    .d   (g2_s),
    .max1(m1_s),
    .max2(m2_s)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      COLLECT: begin
        if (accept_s && group_end_s) begin
          state_nxt_s = MERGE;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      MERGE: begin
        if (last_r) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = COLLECT;
    endcase
  end

  // Slot capture, running top-two, counter and registered result.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < GROUP_N; i++) slot_r[i] <= {DATA_W{1'b0}};
      slot_idx_r <= {IDX_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      run1_r     <= {DATA_W{1'b0}};
      run2_r     <= {DATA_W{1'b0}};
      last_r     <= 1'b0;
      out_max1   <= {DATA_W{1'b0}};
      out_max2   <= {DATA_W{1'b0}};
      out_count  <= {CNT_W{1'b0}};
      out_valid  <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (accept_s) begin
            slot_r[slot_idx_r] <= in_data;
            slot_idx_r         <= slot_idx_r + IDX_W'(1);
            last_r             <= in_last;
            if (cnt_r != {CNT_W{1'b1}}) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        MERGE: begin
          run1_r <= m1_s;
          run2_r <= m2_s;
          if (last_r) begin
            out_max1  <= m1_s;
            out_max2  <= m2_s;
            out_count <= cnt_r;
            out_valid <= 1'b1;
          end else begin
            // Zeroed slots act as neutral padding for a short final group.
            for (int i = 0; i < GROUP_N; i++) slot_r[i] <= {DATA_W{1'b0}};
            slot_idx_r <= {IDX_W{1'b0}};
          end
        end
        DONE: begin
          if (out_ready) begin
            for (int i = 0; i < GROUP_N; i++) slot_r[i] <= {DATA_W{1'b0}};
            slot_idx_r <= {IDX_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            run1_r     <= {DATA_W{1'b0}};
            run2_r     <= {DATA_W{1'b0}};
            last_r     <= 1'b0;
            out_max1   <= {DATA_W{1'b0}};
            out_max2   <= {DATA_W{1'b0}};
            out_count  <= {CNT_W{1'b0}};
            out_valid  <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_min_stream_ctrl.sv
// Directed self-checking bench for max_min_stream_ctrl: frame table plus
// hand-written backpressure, mid-frame reset and counter saturation sequences.
module tb_max_min_stream_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [3:0] out_max1;
  logic [3:0] out_max2;
  logic [7:0] out_count;
  logic       out_valid;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  // Samples packed one per nibble, sample 0 in the lowest nibble.
  typedef struct packed {
    logic [3:0]       n;
    logic [7:0][3:0]  d;
    logic [3:0]       m1;
    logic [3:0]       m2;
    logic [7:0]       cnt;
  } vec_t;

  vec_t vecs [5];

  always #5 sys_clk = ~sys_clk;

  max_min_stream_ctrl #(.DATA_W(4), .CNT_W(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_max1 (out_max1),
    .out_max2 (out_max2),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic send(input logic [3:0] d, input logic last, input int exp_stall);
    int stall = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge sys_clk);
    while (!in_ready && stall < 20) begin
      stall++;
      @(negedge sys_clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'd0;
    check("in_ready_stall", stall, exp_stall);
  endtask

  // Called right after the last accept: MERGE cycle, then first DONE cycle.
  task automatic expect_result(input logic [3:0] m1, input logic [3:0] m2, input logic [7:0] cnt);
    @(negedge sys_clk);
    check("merge_out_valid", out_valid, 1'b0);
    check("merge_in_ready", in_ready, 1'b0);
    @(negedge sys_clk);
    check("done_out_valid", out_valid, 1'b1);
    check("done_in_ready", in_ready, 1'b0);
    check("out_max1", out_max1, m1);
    check("out_max2", out_max2, m2);
    check("out_count", out_count, cnt);
  endtask

  task automatic run_frame(input vec_t v);
    for (int i = 0; i < int'(v.n); i++) begin
      send(v.d[i], (i == int'(v.n) - 1), ((i > 0) && (i % 4 == 0)) ? 1 : 0);
    end
    expect_result(v.m1, v.m2, v.cnt);
    @(negedge sys_clk);
    check("next_in_ready", in_ready, 1'b1);
    check("next_out_valid", out_valid, 1'b0);
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tmp;
    vecs[0] = '{n: 4'd4, d: 32'h0000_4321, m1: 4'd4,  m2: 4'd3,  cnt: 8'd4};
    vecs[1] = '{n: 4'd8, d: 32'hCAB9_5678, m1: 4'd12, m2: 4'd11, cnt: 8'd8};
    vecs[2] = '{n: 4'd3, d: 32'h0000_0155, m1: 4'd5,  m2: 4'd5,  cnt: 8'd3};
    vecs[3] = '{n: 4'd1, d: 32'h0000_0009, m1: 4'd9,  m2: 4'd0,  cnt: 8'd1};
    vecs[4] = '{n: 4'd5, d: 32'h000F_000F, m1: 4'd15, m2: 4'd15, cnt: 8'd5};

    sys_rst   = 1'b1;
    in_data   = 4'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_max1", out_max1, 4'd0);
    check("rst_out_count", out_count, 8'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_max2", out_max2, 4'd0);
    @(posedge sys_clk);
    #1;

    for (int k = 0; k < 5; k++) run_frame(vecs[k]);

    // Backpressure on a finished frame.
    out_ready = 1'b0;
    send(4'd15, 1'b0, 0);
    send(4'd14, 1'b1, 0);
    expect_result(4'd15, 4'd14, 8'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_max1", out_max1, 4'd15);
      check("bp_out_max2", out_max2, 4'd14);
      check("bp_out_count", out_count, 8'd2);
    end
    @(posedge sys_clk);
    #1;
    out_ready = 1'b1;
    @(negedge sys_clk);
    check("hs_out_valid", out_valid, 1'b1);
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    check("after_hs_out_valid", out_valid, 1'b0);
    check("after_hs_in_ready", in_ready, 1'b1);
    @(posedge sys_clk);
    #1;
    tmp = '{n: 4'd2, d: 32'h0000_0013, m1: 4'd3, m2: 4'd1, cnt: 8'd2};
    run_frame(tmp);

    // Reset in the middle of a frame discards it.
    send(4'd13, 1'b0, 0);
    send(4'd14, 1'b0, 0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_in_ready", in_ready, 1'b0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_max1", out_max1, 4'd0);
    check("midrst_out_max2", out_max2, 4'd0);
    check("midrst_out_count", out_count, 8'd0);
    check("midrst_in_ready_after", in_ready, 1'b1);
    @(posedge sys_clk);
    #1;
    tmp = '{n: 4'd2, d: 32'h0000_0012, m1: 4'd2, m2: 4'd1, cnt: 8'd2};
    run_frame(tmp);

    // 300-sample frame: counter saturates at 255 while maxima keep updating.
    for (int i = 0; i < 300; i++) begin
      send((i == 299) ? 4'd15 : 4'(i % 8), (i == 299), ((i > 0) && (i % 4 == 0)) ? 1 : 0);
    end
    expect_result(4'd15, 4'd7, 8'd255);
    @(posedge sys_clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_min_stream_ctrl.md
# max_min_stream_ctrl

Streaming controller for the `max_min` top-two comparator. It accepts a frame of 4-bit unsigned samples over a valid/ready stream and packs them into groups of four. Each group goes through one `max_min` instance, and a second `max_min` instance merges the group result into a running top-two. At frame end it presents the frame's largest and second-largest values with a sample count. It sits between a sample source and any consumer needing per-frame peak statistics.

## Interface
Parameters:
- `DATA_W`, 4: sample width; fixed by `max_min`, not to be overridden.
- `CNT_W`, 8: width of the sample counter.

Ports:
- `sys_clk`, input, 1: single clock; everything is on its rising edge.
- `sys_rst`, input, 1: synchronous, active-high reset.
- `in_data`, input, DATA_W: sample, unsigned.
- `in_valid`, input, 1: `in_data` valid.
- `in_last`, input, 1: the qualified sample is the last of its frame.
- `in_ready`, output, 1: block accepts a sample this cycle.
- `out_max1`, output, DATA_W: largest sample of the frame.
- `out_max2`, output, DATA_W: second-largest sample of the frame (duplicates count).
- `out_count`, output, CNT_W: samples in the frame, saturating at 2^CNT_W−1.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer takes the result.

## Operation
- States:
  - COLLECT: `in_ready` = 1.
  - MERGE: `in_ready` = 0, for exactly one cycle.
  - DONE: `out_valid` = 1, `in_ready` = 0.
- A sample is accepted when `in_valid` and `in_ready` are both high.
- Each accepted sample:
  - is written to group slot `slot_idx` (slots 0..3, in order);
  - increments `slot_idx`;
  - increments the sample counter, saturating.
- COLLECT → MERGE when the accepted sample fills slot 3, or when it carries `in_last`.
- Unfilled slots hold 0. Padding cannot change the result because data is unsigned.
- The group instance `max_min` computes g1 ≥ g2 from the four slots, combinationally.
- The merge instance `max_min` takes (run1, run2, g1, g2). In MERGE, its outputs are registered into run1/run2.
- MERGE exit:
  - If the group was marked last, go to DONE.
  - Otherwise go to COLLECT, with slots cleared to 0 and `slot_idx` = 0.
- DONE:
  - `out_max1` = run1, `out_max2` = run2, `out_count` = counter. These are held stable until `out_valid` and `out_ready` are both high.
  - On that handshake: run1, run2, counter, slots and `slot_idx` clear to 0, and the state goes to COLLECT.
- Result semantics: a multiset top-two.
  - {5,5,1} gives 5, 5.
  - A single-sample frame {9} gives 9, 0.
- `in_last` with `in_valid` low is ignored.

## Timing
- Reset, while `sys_rst` is high and on the cycle after:
  - state = COLLECT;
  - run1, run2, counter, slots and `slot_idx` = 0;
  - `out_valid`, `out_max1`, `out_max2` and `out_count` = 0.
- `in_ready` is gated low while `sys_rst` is high. It goes high on the first cycle after reset is released.
- Reset mid-frame: the partial frame is discarded and nothing is output for it.
- Throughput: 4 accept cycles plus 1 MERGE cycle per full group. `in_ready` is low for exactly one cycle after each full group.
- Latency: the last sample is accepted in cycle N. MERGE occurs in N+1. `out_valid` = 1 from N+2.
- `out_ready` high on the first DONE cycle gives back-to-back frames. The next sample can be accepted in N+3.
- Backpressure in DONE: `in_ready` stays 0, and the outputs are stable for any number of cycles.
- At the saturated count, further samples still update the maxima, but the counter holds.

## Structure
- Package `max_min_pkg` holds:
  - `DATA_W` = 4;
  - `GROUP_N` = 4;
  - the state enum {COLLECT, MERGE, DONE}.
- The sub-module is the existing `max_min`, instantiated twice (group and merge). No other sub-module is needed.
- The FSM, slot registers, counter and output registers are in this module.

## Test plan
- Frame 1,2,3,4 with `in_last` on 4, `out_ready` = 1: `out_max1` = 4, `out_max2` = 3, `out_count` = 4, `out_valid` exactly 2 cycles after the 4th accept.
- Frame 8,7,6,5,9,11,10,12 (`in_last` on 12): result 12, 11, count 8. `in_ready` is low exactly one cycle after sample 5 and again after 12.
- Frame 5,5,1 (`in_last` on 1): result 5, 5, count 3. This covers padding and duplicates.
- Frame of a single sample 9: result 9, 0, count 1.
- Backpressure:
  - Frame 15,14 is done, then `out_ready` is held low 5 cycles. The outputs stay 15, 14, count 2, and `in_ready` stays 0.
  - After the handshake, frame 3,1 gives 3, 1, with no carry-over.
- Reset mid-frame:
  - Accept 13,14, then assert `sys_rst` for 1 cycle. All outputs read 0.
  - Then frame 2,1 gives 2, 1, count 2.
